// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared opcodes, funct codes, control encodings and bubble value
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_LB   = 3'b000;
   localparam logic [2:0] F3_LH   = 3'b001;
   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_LBU  = 3'b100;
   localparam logic [2:0] F3_LHU  = 3'b101;
   localparam logic [2:0] F3_SB   = 3'b000;
   localparam logic [2:0] F3_SH   = 3'b001;
   localparam logic [2:0] F3_SW   = 3'b010;
   localparam logic [2:0] F3_JALR = 3'b000;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SLT  = 4'b0100;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLTU = 4'b0111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;
   localparam logic [1:0] RES_IMM = 2'b11;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       alu_src;
      logic       branch;
      logic       jump;
      logic       jalr;
      logic       md;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   typedef enum logic {MD_IDLE = 1'b0, MD_WAIT = 1'b1} md_state_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational ID decode of opcode/funct fields into the control bundle
module ctrl_decode
   import riscv_ctrl_pkg::*;
#(
   parameter bit M_EXT  = 1'b1,
   parameter int ALUC_W = 4
) (
   input  logic [6:0]        opcode,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic              valid,
   output ctrl_t             ctrl,
   output logic [ALUC_W-1:0] alu_ctrl,
   output logic [2:0]        imm_src,
   output logic              use_rs1,
   output logic              use_rs2,
   output logic              illegal
);

   ctrl_t             c;
   logic [ALUC_W-1:0] alu;
   logic [2:0]        imm;
   logic              u1, u2, ok;

   always_comb begin
      c   = CTRL_BUBBLE;
      alu = ALUC_W'(ALU_ADD);
      imm = IMM_I;
      u1  = 1'b0;
      u2  = 1'b0;
      ok  = 1'b1;
      case (opcode)
         OP_R: begin
            c.reg_write = 1'b1;
            u1 = 1'b1;
            u2 = 1'b1;
            if (funct7 == F7_MULDIV) begin
               if (M_EXT) begin
                  c.md = 1'b1;
                  alu  = ALUC_W'({1'b1, funct3});
               end else begin
                  ok = 1'b0;
               end
            end else if (funct7 == F7_BASE) begin
               case (funct3)
                  F3_ADD:  alu = ALUC_W'(ALU_ADD);
                  F3_AND:  alu = ALUC_W'(ALU_AND);
                  F3_OR:   alu = ALUC_W'(ALU_OR);
                  F3_XOR:  alu = ALUC_W'(ALU_XOR);
                  F3_SLT:  alu = ALUC_W'(ALU_SLT);
                  F3_SLTU: alu = ALUC_W'(ALU_SLTU);
                  default: ok = 1'b0;
               endcase
            end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
               alu = ALUC_W'(ALU_SUB);
            end else begin
               ok = 1'b0;
            end
         end
         OP_I: begin
            c.alu_src   = 1'b1;
            c.reg_write = 1'b1;
            u1 = 1'b1;
            case (funct3)
               F3_ADD:  alu = ALUC_W'(ALU_ADD);
               F3_XOR:  alu = ALUC_W'(ALU_XOR);
               F3_OR:   alu = ALUC_W'(ALU_OR);
               F3_SLT:  alu = ALUC_W'(ALU_SLT);
               F3_SLTU: alu = ALUC_W'(ALU_SLTU);
               default: ok = 1'b0;
            endcase
         end
         OP_LOAD: begin
            c.alu_src    = 1'b1;
            c.result_src = RES_MEM;
            c.reg_write  = 1'b1;
            u1 = 1'b1;
            case (funct3)
               F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ;
               default: ok = 1'b0;
            endcase
         end
         OP_STORE: begin
            c.alu_src   = 1'b1;
            c.mem_write = 1'b1;
            imm = IMM_S;
            u1  = 1'b1;
            u2  = 1'b1;
            case (funct3)
               F3_SB, F3_SH, F3_SW: ;
               default: ok = 1'b0;
            endcase
         end
         OP_BRANCH: begin
            c.branch = 1'b1;
            imm = IMM_B;
            u1  = 1'b1;
            u2  = 1'b1;
            case (funct3)
               F3_BEQ, F3_BNE: alu = ALUC_W'(ALU_SUB);
               F3_BLT, F3_BGE: alu = ALUC_W'(ALU_SLTU);
               default:        ok = 1'b0;
            endcase
         end
         OP_JAL: begin
            c.jump       = 1'b1;
            c.result_src = RES_PC4;
            c.reg_write  = 1'b1;
            imm = IMM_J;
         end
         OP_JALR: begin
            c.jalr       = 1'b1;
            c.alu_src    = 1'b1;
            c.result_src = RES_PC4;
            c.reg_write  = 1'b1;
            u1 = 1'b1;
            ok = (funct3 == F3_JALR);
         end
         OP_LUI: begin
            c.result_src = RES_IMM;
            c.reg_write  = 1'b1;
            imm = IMM_U;
         end
         default: ok = 1'b0;
      endcase
   end

   // Anything that is not a real, supported instruction leaves ID as a full bubble.
   always_comb begin
      illegal = valid & ~ok;
      if (valid && ok) begin
         ctrl     = c;
         alu_ctrl = alu;
         imm_src  = imm;
         use_rs1  = u1;
         use_rs2  = u2;
      end else begin
         ctrl     = CTRL_BUBBLE;
         alu_ctrl = '0;
         imm_src  = 3'b000;
         use_rs1  = 1'b0;
         use_rs2  = 1'b0;
      end
   end

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - staged ID/EX/MEM/WB control with load-use, redirect and mul/div hold logic
module ctrl_pipe
   import riscv_ctrl_pkg::*;
#(
   parameter bit M_EXT  = 1'b1,
   parameter int ALUC_W = 4,
   parameter int RA_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       id_instr,
   input  logic              id_valid,
   input  logic              ex_br_cond,
   input  logic              md_done,
   output logic [2:0]        id_imm_src,
   output logic              id_illegal,
   output logic              stall_f,
   output logic              stall_d,
   output logic              flush_d,
   output logic              flush_e,
   output logic              ex_alu_src,
   output logic              ex_branch,
   output logic              ex_jump,
   output logic              ex_jalr,
   output logic [ALUC_W-1:0] ex_alu_ctrl,
   output logic [RA_W-1:0]   ex_rs1,
   output logic [RA_W-1:0]   ex_rs2,
   output logic [RA_W-1:0]   ex_rd,
   output logic              ex_pc_src,
   output logic              ex_md_start,
   output logic              mem_mem_write,
   output logic              mem_reg_write,
   output logic [1:0]        mem_result_src,
   output logic [RA_W-1:0]   mem_rd,
   output logic              wb_reg_write,
   output logic [1:0]        wb_result_src,
   output logic [RA_W-1:0]   wb_rd
);

   ctrl_t             d_ctrl, ex_c;
   logic [ALUC_W-1:0] d_alu;
   logic              d_use1, d_use2, d_live;
   logic [RA_W-1:0]   d_rs1, d_rs2, d_rd;
   md_state_t         md_state, md_next;
   logic              md_hold, pc_src_raw, lu_hazard;

   ctrl_decode #(.M_EXT(M_EXT), .ALUC_W(ALUC_W)) u_decode (
      .opcode   (id_instr[6:0]),
      .funct3   (id_instr[14:12]),
      .funct7   (id_instr[31:25]),
      .valid    (id_valid),
      .ctrl     (d_ctrl),
      .alu_ctrl (d_alu),
      .imm_src  (id_imm_src),
      .use_rs1  (d_use1),
      .use_rs2  (d_use2),
      .illegal  (id_illegal)
   );

   assign d_live = id_valid & ~id_illegal;
   assign d_rs1  = d_live ? RA_W'(id_instr[19:15]) : '0;
   assign d_rs2  = d_live ? RA_W'(id_instr[24:20]) : '0;
   assign d_rd   = d_live ? RA_W'(id_instr[11:7])  : '0;

   always_ff @(posedge clk) begin
      if (rst) md_state <= MD_IDLE;
      else     md_state <= md_next;
   end

   always_comb begin
      md_next = md_state;
      case (md_state)
         MD_IDLE: if (ex_c.md && !md_done) md_next = MD_WAIT;
         MD_WAIT: if (md_done)             md_next = MD_IDLE;
         default: md_next = MD_IDLE;
      endcase
      if (!M_EXT) md_next = MD_IDLE;
   end

   // The md op sits in EX from its start cycle until md_done; a same-cycle done never holds.
   always_comb begin
      md_hold     = 1'b0;
      ex_md_start = 1'b0;
      if (M_EXT && !rst) begin
         md_hold     = ex_c.md & ~md_done;
         ex_md_start = ex_c.md & (md_state == MD_IDLE);
      end
   end

   always_comb begin
      pc_src_raw = ex_c.jump | ex_c.jalr | (ex_c.branch & ex_br_cond);
      lu_hazard  = (ex_c.result_src == RES_MEM) & ex_c.reg_write & (ex_rd != '0)
                 & ((d_use1 & (d_rs1 == ex_rd)) | (d_use2 & (d_rs2 == ex_rd)));
      ex_pc_src  = ~rst & pc_src_raw;
      flush_d    = ~rst & ~md_hold & pc_src_raw;
      flush_e    = ~rst & ~md_hold & (pc_src_raw | lu_hazard);
      stall_f    = ~rst & (md_hold | (lu_hazard & ~pc_src_raw));
      stall_d    = stall_f;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_c           <= CTRL_BUBBLE;
         ex_alu_ctrl    <= '0;
         ex_rs1         <= '0;
         ex_rs2         <= '0;
         ex_rd          <= '0;
         mem_mem_write  <= 1'b0;
         mem_reg_write  <= 1'b0;
         mem_result_src <= 2'b00;
         mem_rd         <= '0;
         wb_reg_write   <= 1'b0;
         wb_result_src  <= 2'b00;
         wb_rd          <= '0;
      end else begin
         if (!md_hold) begin
            if (flush_e) begin
               ex_c        <= CTRL_BUBBLE;
               ex_alu_ctrl <= '0;
               ex_rs1      <= '0;
               ex_rs2      <= '0;
               ex_rd       <= '0;
            end else begin
               ex_c        <= d_ctrl;
               ex_alu_ctrl <= d_alu;
               ex_rs1      <= d_rs1;
               ex_rs2      <= d_rs2;
               ex_rd       <= d_rd;
            end
         end
         if (md_hold) begin
            mem_mem_write  <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_result_src <= 2'b00;
            mem_rd         <= '0;
         end else begin
            mem_mem_write  <= ex_c.mem_write;
            mem_reg_write  <= ex_c.reg_write;
            mem_result_src <= ex_c.result_src;
            mem_rd         <= ex_rd;
         end
         wb_reg_write  <= mem_reg_write;
         wb_result_src <= mem_result_src;
         wb_rd         <= mem_rd;
      end
   end

   assign ex_alu_src = ex_c.alu_src;
   assign ex_branch  = ex_c.branch;
   assign ex_jump    = ex_c.jump;
   assign ex_jalr    = ex_c.jalr;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - directed and random checks of ctrl_pipe against a reference pipeline model
module tb_ctrl_pipe;

   logic clk = 1'b0;
   logic rst, id_valid, ex_br_cond, md_done;
   logic [31:0] id_instr;
   always #5 clk = ~clk;

   logic [2:0] id_imm_src, n_id_imm_src;
   logic id_illegal, stall_f, stall_d, flush_d, flush_e, ex_alu_src, ex_branch, ex_jump, ex_jalr;
   logic ex_pc_src, ex_md_start, mem_mem_write, mem_reg_write, wb_reg_write;
   logic [3:0] ex_alu_ctrl, n_ex_alu_ctrl;
   logic [4:0] ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd, n_ex_rs1, n_ex_rs2, n_ex_rd, n_mem_rd, n_wb_rd;
   logic [1:0] mem_result_src, wb_result_src, n_mem_result_src, n_wb_result_src;
   logic n_id_illegal, n_stall_f, n_stall_d, n_flush_d, n_flush_e, n_ex_alu_src, n_ex_branch;
   logic n_ex_jump, n_ex_jalr, n_ex_pc_src, n_ex_md_start, n_mem_mem_write, n_mem_reg_write, n_wb_reg_write;

   ctrl_pipe #(.M_EXT(1'b1), .ALUC_W(4), .RA_W(5)) u_m (
      .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .ex_br_cond(ex_br_cond),
      .md_done(md_done), .id_imm_src(id_imm_src), .id_illegal(id_illegal), .stall_f(stall_f),
      .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e), .ex_alu_src(ex_alu_src),
      .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr), .ex_alu_ctrl(ex_alu_ctrl),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_pc_src(ex_pc_src), .ex_md_start(ex_md_start),
      .mem_mem_write(mem_mem_write), .mem_reg_write(mem_reg_write), .mem_result_src(mem_result_src),
      .mem_rd(mem_rd), .wb_reg_write(wb_reg_write), .wb_result_src(wb_result_src), .wb_rd(wb_rd));

   ctrl_pipe #(.M_EXT(1'b0), .ALUC_W(4), .RA_W(5)) u_n (
      .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .ex_br_cond(ex_br_cond),
      .md_done(md_done), .id_imm_src(n_id_imm_src), .id_illegal(n_id_illegal), .stall_f(n_stall_f),
      .stall_d(n_stall_d), .flush_d(n_flush_d), .flush_e(n_flush_e), .ex_alu_src(n_ex_alu_src),
      .ex_branch(n_ex_branch), .ex_jump(n_ex_jump), .ex_jalr(n_ex_jalr), .ex_alu_ctrl(n_ex_alu_ctrl),
      .ex_rs1(n_ex_rs1), .ex_rs2(n_ex_rs2), .ex_rd(n_ex_rd), .ex_pc_src(n_ex_pc_src),
      .ex_md_start(n_ex_md_start), .mem_mem_write(n_mem_mem_write), .mem_reg_write(n_mem_reg_write),
      .mem_result_src(n_mem_result_src), .mem_rd(n_mem_rd), .wb_reg_write(n_wb_reg_write),
      .wb_result_src(n_wb_result_src), .wb_rd(n_wb_rd));

   typedef struct packed {
      logic rw; logic [1:0] rs; logic mw, as, br, j, jr, md;
      logic [3:0] alu; logic [4:0] rs1, rs2, rd; logic u1, u2, ill; logic [2:0] imm;
   } dec_t;

   int n_assert = 0;
   int n_fail   = 0;
   dec_t d, m_ex;
   logic m_mem_rw, m_mem_mw, m_wb_rw, m_started;
   logic [1:0] m_mem_rs, m_wb_rs;
   logic [4:0] m_mem_rd, m_wb_rd;
   logic pc, blk, lu, e_stall, e_fd, e_fe, e_start;
   logic [31:0] cur;
   logic cur_v;
   int stall_cnt, bubble_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // RV32I base ALU op by funct3; 4'hF marks a funct3 with no listed operation.
   function automatic logic [3:0] base_alu(input logic [2:0] f3);
      case (f3)
         3'd0: return 4'd2;  3'd2: return 4'd4;  3'd3: return 4'd7;
         3'd4: return 4'd3;  3'd6: return 4'd1;  3'd7: return 4'd0;
         default: return 4'hF;
      endcase
   endfunction

   function automatic dec_t ref_dec(input logic [31:0] i, input logic v);
      dec_t r; logic ok; logic [2:0] f3; logic [6:0] f7;
      r = '0; ok = 1'b1; f3 = i[14:12]; f7 = i[31:25];
      r.rs1 = i[19:15]; r.rs2 = i[24:20]; r.rd = i[11:7]; r.alu = 4'd2;
      case (i[6:0])
         7'h33: begin
            r.rw = 1; r.u1 = 1; r.u2 = 1;
            if (f7 == 7'h01) begin r.md = 1; r.alu = 4'd8 + {1'b0, f3}; end
            else if (f7 == 7'h00) begin r.alu = base_alu(f3); ok = (r.alu != 4'hF); end
            else if (f7 == 7'h20 && f3 == 3'd0) r.alu = 4'd6;
            else ok = 0;
         end
         7'h13: begin r.as = 1; r.rw = 1; r.u1 = 1; r.alu = base_alu(f3); ok = (r.alu != 4'hF) && f3 != 3'd7; end
         7'h03: begin r.as = 1; r.rs = 2'b01; r.rw = 1; r.u1 = 1; ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; end
         7'h23: begin r.as = 1; r.mw = 1; r.u1 = 1; r.u2 = 1; r.imm = 3'd1; ok = f3 <= 3'd2; end
         7'h63: begin
            r.br = 1; r.u1 = 1; r.u2 = 1; r.imm = 3'd2;
            ok = f3 inside {3'd0, 3'd1, 3'd4, 3'd5};
            r.alu = f3[2] ? 4'd7 : 4'd6;
         end
         7'h6F: begin r.j = 1; r.rs = 2'b10; r.rw = 1; r.imm = 3'd3; end
         7'h67: begin r.jr = 1; r.as = 1; r.rs = 2'b10; r.rw = 1; r.u1 = 1; ok = (f3 == 3'd0); end
         7'h37: begin r.rs = 2'b11; r.rw = 1; r.imm = 3'd4; end
         default: ok = 0;
      endcase
      if (!v || !ok) begin r = '0; r.ill = v && !ok; end
      return r;
   endfunction

   function automatic logic [31:0] gen();
      logic [4:0] rd, a, b; logic [2:0] f3; logic [11:0] im; int k;
      rd = 5'($urandom_range(0, 3)); a = 5'($urandom_range(0, 3)); b = 5'($urandom_range(0, 3));
      im = 12'($urandom); k = $urandom_range(0, 6);
      case ($urandom_range(0, 11))
         0: case (k)
               0: return {7'h00, b, a, 3'd0, rd, 7'h33};
               1: return {7'h20, b, a, 3'd0, rd, 7'h33};
               2: return {7'h00, b, a, 3'd7, rd, 7'h33};
               3: return {7'h00, b, a, 3'd6, rd, 7'h33};
               4: return {7'h00, b, a, 3'd4, rd, 7'h33};
               5: return {7'h00, b, a, 3'd2, rd, 7'h33};
               default: return {7'h00, b, a, 3'd3, rd, 7'h33};
            endcase
         1: return {7'h01, b, a, 3'($urandom), rd, 7'h33};
         2: begin
            f3 = (k < 2) ? 3'd0 : (k == 2) ? 3'd4 : (k == 3) ? 3'd6 : (k == 4) ? 3'd2 : 3'd3;
            return {im, a, f3, rd, 7'h13};
         end
         3, 11: return {im, a, 3'd2, rd, 7'h03};
         4: return {im[11:5], b, a, 3'd2, im[4:0], 7'h23};
         5: return {7'h00, b, a, (k < 2) ? 3'd0 : (k < 4) ? 3'd1 : (k < 6) ? 3'd4 : 3'd5, 5'd0, 7'h63};
         6: return {20'($urandom), rd, 7'h6F};
         7: return {im, a, 3'd0, rd, 7'h67};
         8: return {20'($urandom), rd, 7'h37};
         9: return $urandom;
         default: return {7'h00, b, a, 3'd1, rd, 7'h33};
      endcase
   endfunction

   task automatic step_check();
      #1;
      d   = ref_dec(id_instr, id_valid);
      pc  = !rst && (m_ex.j || m_ex.jr || (m_ex.br && ex_br_cond));
      blk = !rst && m_ex.md && !md_done;
      lu  = !rst && m_ex.rs == 2'b01 && m_ex.rw && m_ex.rd != 0 &&
            ((d.u1 && d.rs1 == m_ex.rd) || (d.u2 && d.rs2 == m_ex.rd));
      e_stall = blk || (lu && !pc);
      e_fd    = pc && !blk;
      e_fe    = !blk && (pc || lu);
      e_start = !rst && m_ex.md && !m_started;
      chk("stall_f", stall_f, e_stall);       chk("stall_d", stall_d, e_stall);
      chk("flush_d", flush_d, e_fd);          chk("flush_e", flush_e, e_fe);
      chk("ex_pc_src", ex_pc_src, pc);        chk("ex_md_start", ex_md_start, e_start);
      chk("id_illegal", id_illegal, d.ill);   chk("id_imm_src", id_imm_src, d.imm);
      chk("ex_alu_src", ex_alu_src, m_ex.as); chk("ex_branch", ex_branch, m_ex.br);
      chk("ex_jump", ex_jump, m_ex.j);        chk("ex_jalr", ex_jalr, m_ex.jr);
      chk("ex_alu_ctrl", ex_alu_ctrl, m_ex.alu);
      chk("ex_rs1", ex_rs1, m_ex.rs1); chk("ex_rs2", ex_rs2, m_ex.rs2); chk("ex_rd", ex_rd, m_ex.rd);
      chk("mem_mem_write", mem_mem_write, m_mem_mw); chk("mem_reg_write", mem_reg_write, m_mem_rw);
      chk("mem_result_src", mem_result_src, m_mem_rs); chk("mem_rd", mem_rd, m_mem_rd);
      chk("wb_reg_write", wb_reg_write, m_wb_rw); chk("wb_result_src", wb_result_src, m_wb_rs);
      chk("wb_rd", wb_rd, m_wb_rd);
      chk("n_ex_md_start", n_ex_md_start, 1'b0);
   endtask

   task automatic step_clock();
      if (rst) begin
         m_ex = '0; m_started = 0;
         {m_mem_rw, m_mem_mw, m_mem_rs, m_mem_rd} = '0;
         {m_wb_rw, m_wb_rs, m_wb_rd} = '0;
      end else begin
         m_wb_rw = m_mem_rw; m_wb_rs = m_mem_rs; m_wb_rd = m_mem_rd;
         if (blk) begin
            {m_mem_rw, m_mem_mw, m_mem_rs, m_mem_rd} = '0;
            m_started = 1;
         end else begin
            m_mem_rw = m_ex.rw; m_mem_mw = m_ex.mw; m_mem_rs = m_ex.rs; m_mem_rd = m_ex.rd;
            m_ex = (pc || lu) ? '0 : d;
            m_started = 0;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic put(input logic [31:0] i, input logic v);
      id_instr = i; id_valid = v;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         put(32'h0, 1'b0); ex_br_cond = 0; md_done = 0;
         step_check(); step_clock();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; id_instr = 0; id_valid = 0; ex_br_cond = 0; md_done = 0;
      m_ex = '0; m_started = 0;
      {m_mem_rw, m_mem_mw, m_mem_rs, m_mem_rd} = '0;
      {m_wb_rw, m_wb_rs, m_wb_rd} = '0;
      @(posedge clk); #1;
      put(32'h0000A283, 1'b1); ex_br_cond = 1; md_done = 1;
      step_check(); chk("rst_stall_f", stall_f, 0); chk("rst_ex_rd", ex_rd, 0); step_clock();
      step_check(); step_clock();
      rst = 0; ex_br_cond = 0; md_done = 0;
      idle(2);

      // lw x5 then add x6,x5,x1: one load-use stall cycle
      put(32'h0000A283, 1'b1); step_check(); step_clock();
      put(32'h00128333, 1'b1); step_check();
      chk("lu_stall_f", stall_f, 1); chk("lu_stall_d", stall_d, 1);
      chk("lu_flush_e", flush_e, 1); chk("lu_flush_d", flush_d, 0); step_clock();
      step_check(); chk("lu_once", stall_f, 0); step_clock();
      put(32'h0, 1'b0); step_check(); chk("lu_add_rs1", ex_rs1, 5); chk("lu_add_rd", ex_rd, 6); step_clock();
      put(32'h0000A003, 1'b1); step_check(); step_clock();
      put(32'h00100333, 1'b1); step_check(); chk("x0_no_stall", stall_f, 0); step_clock();
      idle(2);

      // taken beq flushes
      put(32'h00208063, 1'b1); step_check(); step_clock();
      put(32'h0, 1'b0); ex_br_cond = 1; step_check();
      chk("beq_pc_src", ex_pc_src, 1); chk("beq_flush_d", flush_d, 1); chk("beq_flush_e", flush_e, 1);
      step_clock(); ex_br_cond = 0;
      step_check(); chk("beq_after_branch", ex_branch, 0); chk("beq_after_rd", ex_rd, 0); step_clock();
      idle(1);

      // jal in EX with a load in ID: flush only
      put(32'h000000EF, 1'b1); step_check(); step_clock();
      put(32'h0000A283, 1'b1); step_check();
      chk("jal_pc_src", ex_pc_src, 1); chk("jal_no_stall", stall_f, 0); step_clock();
      idle(2);

      // div x7,x1,x2 with md_done four cycles after start
      put(32'h0220C3B3, 1'b1); step_check(); step_clock();
      put(32'h0, 1'b0); stall_cnt = 0; bubble_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         step_check();
         chk("div_start", ex_md_start, (k == 0));
         if (k == 0) chk("div_alu", ex_alu_ctrl, 4'b1100);
         stall_cnt += int'(stall_f);
         step_clock();
         bubble_cnt += int'(mem_reg_write == 1'b0 && mem_rd == 5'd0);
      end
      chk("div_stall_cycles", stall_cnt, 4); chk("div_bubbles", bubble_cnt, 4);
      md_done = 1; step_check(); chk("div_release", stall_f, 0); step_clock(); md_done = 0;
      chk("div_mem_rd", mem_rd, 7); chk("div_mem_rw", mem_reg_write, 1);
      idle(2);

      // mul: illegal with M_EXT=0, single-cycle with M_EXT=1
      put(32'h02208033, 1'b1); step_check(); chk("n_mul_illegal", n_id_illegal, 1); step_clock();
      put(32'h0, 1'b0); md_done = 1; step_check();
      chk("n_mul_bubble", n_ex_alu_ctrl, 0); chk("n_mul_start", n_ex_md_start, 0);
      chk("mul_single_start", ex_md_start, 1); chk("mul_single_nostall", stall_f, 0);
      step_clock(); md_done = 0;
      chk("mul_single_mem", mem_reg_write, 1);
      idle(2);

      // reset while waiting on a divide
      put(32'h0220C3B3, 1'b1); step_check(); step_clock();
      put(32'h0, 1'b0); step_check(); step_clock();
      step_check(); chk("wait_stall", stall_f, 1); step_clock();
      rst = 1; step_check(); chk("rst_wait_stall", stall_f, 0); chk("rst_wait_start", ex_md_start, 0); step_clock();
      rst = 0; step_check();
      chk("post_rst_stall", stall_f, 0); chk("post_rst_ex_rd", ex_rd, 0);
      chk("post_rst_mem_rw", mem_reg_write, 0); chk("post_rst_start", ex_md_start, 0);
      step_clock();

      // random traffic with fetch following the expected stall/flush
      cur = gen(); cur_v = 1;
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 79) == 0);
         ex_br_cond = 1'($urandom);
         md_done = ($urandom_range(0, 2) == 0);
         put(cur, cur_v);
         step_check();
         if (!e_stall) begin
            if (e_fd) cur_v = 0;
            else begin cur = gen(); cur_v = ($urandom_range(0, 9) != 0); end
         end
         step_clock();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control path for the 5-stage RV32I core, with optional RV32M. Decodes the instruction in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB control registers. Generates load-use stalls, taken-branch and jump flushes, and a hold/handshake for a multi-cycle mul/div unit. The datapath consumes the staged control outputs; the fetch and decode registers obey its stall and flush outputs.

## Interface
- M_EXT, 1: 1 enables RV32M decode and the mul/div handshake; 0 treats func7=0000001 R-type as illegal.
- ALUC_W, 4: ALU control width; must be ≥4 when M_EXT=1.
- RA_W, 5: register address width.

Ports:
- clk  in  1  clock. One clock domain.
- rst  in  1  synchronous, active-high reset.
- id_instr  in  32  instruction in ID.
- id_valid  in  1  ID holds a real instruction; 0 decodes as bubble.
- ex_br_cond  in  1  branch condition evaluated by the EX comparator.
- md_done  in  1  one-cycle pulse: mul/div result ready.
- id_imm_src  out  3  immediate select for the ID extender, combinational.
- id_illegal  out  1  unsupported opcode/funct in ID with id_valid=1.
- stall_f, stall_d  out  1 each  hold the PC and IF/ID registers.
- flush_d, flush_e  out  1 each  clear IF/ID and ID/EX.
- ex_alu_src, ex_branch, ex_jump, ex_jalr  out  1 each  registered EX control.
- ex_alu_ctrl  out  ALUC_W  ALU operation.
- ex_rs1, ex_rs2, ex_rd  out  RA_W each  EX register addresses for forwarding.
- ex_pc_src  out  1  = ex_jump | ex_jalr | (ex_branch & ex_br_cond).
- ex_md_start  out  1  one-cycle start pulse to the mul/div unit.
- mem_mem_write, mem_reg_write  out  1 each. mem_result_src  out  2. mem_rd  out  RA_W.
- wb_reg_write  out  1. wb_result_src  out  2. wb_rd  out  RA_W.

## Operation
- Decode (ID):
  - ImmSrc: I=000, S=001, B=010, J=011, U=100.
  - ResultSrc: 00 ALU, 01 memory, 10 PC+4, 11 immediate.
  - ALU codes: and 0000, or 0001, add 0010, xor 0011, slt 0100, sub 0110, sltu 0111.
  - M ops: 1000+func3 (mul through remu).
- Per-opcode decode:
  - R-type: reg_write=1.
  - I-type: alu_src=1, reg_write=1; addi/xori/ori/slti/sltiu.
  - Load: alu_src=1, result_src=01, reg_write=1.
  - Store: alu_src=1, mem_write=1.
  - Branch: branch=1. beq/bne use sub; blt/bge use sltu.
  - JAL: jump=1, result_src=10, reg_write=1.
  - JALR: jalr=1, alu_src=1, result_src=10, reg_write=1.
  - LUI: result_src=11, reg_write=1.
  - Unknown: bubble with id_illegal=1.
- Register usage:
  - rs1 is used by R, I, load, store, branch and JALR.
  - rs2 is used by R, store and branch.
  - Unused rs fields never cause a stall.
- Bubble: every control bit 0, rd=0.
- Load-use:
  - Condition: ex_result_src=01 & ex_reg_write & ex_rd≠0 & ex_rd matches a used ID rs.
  - Response: stall_f=stall_d=1, flush_e=1, for exactly one cycle per hazard.
- Control redirect: ex_pc_src=1 sets flush_d=flush_e=1 and suppresses the load-use stall.
- Mul/div state machine (M_EXT=1), states IDLE and WAIT:
  - IDLE→WAIT when an md op is in EX; ex_md_start=1 for that single cycle.
  - In WAIT: ID/EX is held, stall_f=stall_d=1, and a bubble is inserted into EX/MEM each cycle.
  - WAIT→IDLE on md_done. The md instruction then advances to MEM on that same edge with mem_reg_write=1.
- Priority: rst > md hold > ex_pc_src flush > load-use stall. Flushes never clear a held md instruction, because an md op is never a branch.
- M_EXT=0: the state machine is constant IDLE and ex_md_start=0.

## Timing
- Reset:
  - All EX/MEM/WB registered outputs are 0 and the state is IDLE.
  - The combinational outputs stall_*, flush_*, ex_pc_src and ex_md_start evaluate to 0 while in reset.
- ID→EX control latency is 1 cycle; EX→MEM is 1 cycle; MEM→WB is 1 cycle.
- md_done arriving in the same cycle as ex_md_start is legal (single-cycle op): no WAIT cycles, the instruction advances immediately.
- md_done in IDLE is ignored.
- rst while in WAIT returns to IDLE on the next edge and clears every pipeline register.
- stall_d holding IF/ID does not block EX/MEM/WB advancing.

## Structure
- Shared package riscv_ctrl_pkg holds:
  - opcode constants;
  - func3/func7 constants;
  - ALU code, ImmSrc and ResultSrc constants;
  - the bubble value.
- One sub-module, ctrl_decode: purely combinational instruction→control bundle, parametrised by M_EXT and ALUC_W.
- Hazard, flush and mul/div state-machine logic plus the three control registers live in ctrl_pipe.

## Test plan
- After reset: `lw x5` then `add x6,x5,x1` → one cycle with stall_f=stall_d=flush_e=1; the add reaches EX with ex_rs1=5 one cycle later. `lw x0` followed by a use of x0 → no stall.
- `beq` in EX with ex_br_cond=1 → ex_pc_src=flush_d=flush_e=1 for one cycle. Next cycle ex_branch=0 and ex_rd=0.
- Load-use pair in ID/EX coinciding with a taken `jal` in EX → flush only, stall_f=0.
- `div x7,x1,x2` with md_done 4 cycles after start:
  - ex_md_start is high for 1 cycle;
  - stalls are high for 4 cycles, with 4 bubbles at MEM;
  - then mem_rd=7 and mem_reg_write=1.
- M_EXT=0, instruction 0x02208033 (mul) → id_illegal=1, bubble in EX, ex_md_start stays 0.
- rst asserted during WAIT → next cycle state IDLE, all registered outputs 0, stalls 0.
